// File: rtl/regfile_debug_arbiter_if.sv
// Debug request/response channel between the debug requester and the register-file arbiter.
// The requester drives the master side and the arbiter implements the slave side.
interface regfile_debug_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 5
);
    logic                  dbg_req_valid_i;
    logic                  dbg_req_ready_o;
    logic                  dbg_req_we_i;
    logic [ADDR_W:0]       dbg_req_addr_i;
    logic [DATA_WIDTH-1:0] dbg_req_wdata_i;
    logic                  dbg_rsp_valid_o;
    logic                  dbg_rsp_ready_i;
    logic [DATA_WIDTH-1:0] dbg_rsp_rdata_o;
    logic                  dbg_rsp_err_o;

    modport master (
        output dbg_req_valid_i,
        output dbg_req_we_i,
        output dbg_req_addr_i,
        output dbg_req_wdata_i,
        output dbg_rsp_ready_i,
        input  dbg_req_ready_o,
        input  dbg_rsp_valid_o,
        input  dbg_rsp_rdata_o,
        input  dbg_rsp_err_o
    );

    modport slave (
        input  dbg_req_valid_i,
        input  dbg_req_we_i,
        input  dbg_req_addr_i,
        input  dbg_req_wdata_i,
        input  dbg_rsp_ready_i,
        output dbg_req_ready_o,
        output dbg_rsp_valid_o,
        output dbg_rsp_rdata_o,
        output dbg_rsp_err_o
    );
endinterface

// File: rtl/regfile_debug_arbiter.sv
// Shares the integer register file between the core pipeline and a debug requester:
// halts the core, waits for it to drain, performs one access, and returns a response.
module regfile_debug_arbiter #(
    parameter int  DATA_WIDTH   = 32,
    parameter int  NUM_REGISTER = 32,
    parameter int  TIMEOUT      = 64,
    localparam int ADDR_W       = $clog2(NUM_REGISTER)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    regfile_debug_arbiter_if.slave dbg,
    input  logic                  core_we_i,
    input  logic [ADDR_W-1:0]     core_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] core_rd_i,
    input  logic [ADDR_W-1:0]     core_rs1_addr_i,
    input  logic [ADDR_W-1:0]     core_rs2_addr_i,
    output logic                  core_stall_o,
    input  logic                  core_idle_i,
    output logic                  rf_we_o,
    output logic [ADDR_W-1:0]     rf_rd_addr_o,
    output logic [DATA_WIDTH-1:0] rf_rd_o,
    output logic [ADDR_W-1:0]     rf_rs1_addr_o,
    output logic [ADDR_W-1:0]     rf_rs2_addr_o,
    input  logic [DATA_WIDTH-1:0] rf_rs1_i
);

    localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]  ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGISTER);

    typedef enum logic [1:0] {
        IDLE,
        HALT,
        ACCESS,
        RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  r_stall;

    logic                  w_addr_bad;
    logic                  w_req_ready;
    logic                  w_rsp_valid;

    assign w_addr_bad = (dbg.dbg_req_addr_i >= ADDR_LIMIT);

    assign dbg.dbg_req_ready_o = w_req_ready;
    assign dbg.dbg_rsp_valid_o = w_rsp_valid;
    assign dbg.dbg_rsp_rdata_o = r_rdata;
    assign dbg.dbg_rsp_err_o   = r_err;
    assign core_stall_o        = r_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_req_ready   = 1'b0;
        w_rsp_valid   = 1'b0;
        rf_we_o       = core_we_i;
        rf_rd_addr_o  = core_rd_addr_i;
        rf_rd_o       = core_rd_i;
        rf_rs1_addr_o = core_rs1_addr_i;
        rf_rs2_addr_o = core_rs2_addr_i;

        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (dbg.dbg_req_valid_i) begin
                    // Out-of-range requests answer immediately and never disturb the core.
                    w_state_nxt = w_addr_bad ? RESP : HALT;
                end
            end
            HALT: begin
                if (core_idle_i) begin
                    w_state_nxt = ACCESS;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = RESP;
                end
            end
            ACCESS: begin
                // The core write port is taken over; x0 is never written.
                rf_we_o       = r_we && (r_addr != '0);
                rf_rd_addr_o  = r_addr;
                rf_rd_o       = r_wdata;
                rf_rs1_addr_o = r_addr;
                w_state_nxt   = RESP;
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (dbg.dbg_rsp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (rst_i) begin
            rf_we_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_stall <= 1'b0;
        end else begin
            r_stall <= (w_state_nxt == HALT) || (w_state_nxt == ACCESS);
            case (r_state)
                IDLE: begin
                    if (dbg.dbg_req_valid_i) begin
                        r_we    <= dbg.dbg_req_we_i;
                        r_addr  <= dbg.dbg_req_addr_i[ADDR_W-1:0];
                        r_wdata <= dbg.dbg_req_wdata_i;
                        r_rdata <= '0;
                        r_err   <= w_addr_bad;
                        r_cnt   <= '0;
                    end
                end
                HALT: begin
                    // Idle wins over timeout; the counter stops at its last value.
                    if (!core_idle_i) begin
                        if (r_cnt == CNT_LAST) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    r_rdata <= r_we ? '0 : rf_rs1_i;
                end
                RESP: begin
                    if (dbg.dbg_rsp_ready_i) begin
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/regfile_debug_arbiter.md
Name: regfile_debug_arbiter

Overview:
- Shares the integer register file between the core pipeline and a debug requester (the future TAP/debug module).
- The core owns the register-file ports by default, and they pass straight through.
- On a debug request, the block halts the core and waits for it to drain. It then performs one register read or write through the core's ports and returns a response over a valid/ready handshake.
- Sits between the decode/writeback stages and the register file.

Parameters:
- DATA_WIDTH, 32, register width.
- NUM_REGISTER, 32, number of architectural registers; ADDR_W = $clog2(NUM_REGISTER).
- TIMEOUT, 64, maximum number of cycles spent in HALT waiting for core_idle_i before the access is aborted.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- dbg_req_valid_i  in  1  debug request valid.
- dbg_req_ready_o  out  1  request accepted when valid and ready are both high.
- dbg_req_we_i  in  1  1 = write, 0 = read.
- dbg_req_addr_i  in  ADDR_W+1  register index; the extra bit allows out-of-range detection.
- dbg_req_wdata_i  in  DATA_WIDTH  write data.
- dbg_rsp_valid_o  out  1  response valid.
- dbg_rsp_ready_i  in  1  response consumed.
- dbg_rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors.
- dbg_rsp_err_o  out  1  bad address or halt timeout.
- core_we_i, core_rd_addr_i, core_rd_i  in  1/ADDR_W/DATA_WIDTH  core writeback port.
- core_rs1_addr_i, core_rs2_addr_i  in  ADDR_W  core read addresses.
- core_stall_o  out  1  halt request to the pipeline.
- core_idle_i  in  1  pipeline stalled, with no writeback in flight.
- rf_we_o, rf_rd_addr_o, rf_rd_o  out  1/ADDR_W/DATA_WIDTH  to the register-file write port.
- rf_rs1_addr_o, rf_rs2_addr_o  out  ADDR_W  to the register-file read ports.
- rf_rs1_i  in  DATA_WIDTH  register-file rs1 read data (combinational).

Behaviour:
- FSM states: IDLE, HALT, ACCESS, RESP. The state and all latched fields are registers.
- Reset (rst_i high at a clock edge):
  - state = IDLE; counter = 0; latched we/addr/wdata/rdata/err = 0.
  - Outputs after reset: dbg_req_ready_o = 1, dbg_rsp_valid_o = 0, core_stall_o = 0, dbg_rsp_rdata_o = 0, dbg_rsp_err_o = 0.
  - rf_we_o is forced to 0 while rst_i is high.
- Pass-through: in every state except ACCESS, the rf_* outputs equal the corresponding core_* inputs combinationally.
- IDLE:
  - dbg_req_ready_o = 1.
  - On handshake, latch we/addr/wdata.
  - If addr >= NUM_REGISTER: set err = 1, rdata = 0, go to RESP. The core is never stalled in this case.
  - Otherwise clear the counter and go to HALT.
- HALT:
  - core_stall_o = 1.
  - If core_idle_i = 1: go to ACCESS. This check takes priority over timeout.
  - Else if counter == TIMEOUT-1: set err = 1, go to RESP.
  - Else counter += 1.
  - The counter saturates and never wraps.
- ACCESS (exactly 1 cycle):
  - core_stall_o = 1; core_we_i is masked.
  - Read: rf_rs1_addr_o = latched addr; rdata <= rf_rs1_i at the clock edge; rf_we_o = 0.
  - Write: rf_we_o = 1, rf_rd_addr_o = addr, rf_rd_o = wdata, rdata <= 0. A write to x0 drives rf_we_o = 0 and returns err = 0.
  - rf_rs2_addr_o still follows core_rs2_addr_i.
  - Go to RESP.
- RESP:
  - core_stall_o = 0; dbg_rsp_valid_o = 1 with rdata/err held stable.
  - On dbg_rsp_ready_i = 1: clear err, go to IDLE.
  - dbg_req_ready_o = 0 in every state except IDLE. A new request is accepted no earlier than the cycle after the response handshake.
- Latency: with core_idle_i already high, a read accepted at edge N enters HALT (N), ACCESS (N+1) and RESP (N+2). dbg_rsp_valid_o is therefore visible in the cycle after edge N+2.
- core_stall_o is a registered function of state and is high exactly in HALT and ACCESS.
- Simultaneous events:
  - A debug request never interrupts a core write outside ACCESS.
  - core_idle_i rising on the same cycle the counter reaches TIMEOUT-1 → ACCESS, not an error.
  - Any core_we_i during ACCESS is dropped. This is a core contract violation and is not flagged.
- Reset mid-operation: state returns to IDLE on the next edge, stall is released, and any pending response is discarded without a handshake.

Test Plan:
- Pass-through: with no debug request, drive core_we_i = 1, rd_addr = 5, rd = 0xDEADBEEF → rf_we_o/rf_rd_addr_o/rf_rd_o match in the same cycle; core_stall_o stays 0.
- Debug read: core_idle_i tied to 1, register-file model has x7 = 0x12345678, request read addr 7 → core_stall_o high for 2 cycles, rf_rs1_addr_o = 7 in ACCESS, response rdata = 0x12345678, err = 0.
- Debug write, delayed idle: core_idle_i rises 10 cycles after HALT entry, request write x3 = 0xCAFEF00D → a single rf_we_o pulse with addr 3 / data 0xCAFEF00D, core_we_i = 1 masked in that cycle, response err = 0, rdata = 0.
- Timeout: core_idle_i held at 0 → exactly 64 stall cycles, then a response with err = 1, core_stall_o = 0 in RESP, and no rf_we_o pulse.
- Bad address and backpressure: request addr 32 → RESP the cycle after acceptance with no stall and err = 1. Hold dbg_rsp_ready_i = 0 for 5 cycles → valid and err stay stable, dbg_req_ready_o = 0 throughout.
- Reset in HALT: assert rst_i during the 3rd HALT cycle → next cycle core_stall_o = 0, dbg_rsp_valid_o = 0, dbg_req_ready_o = 1, with no response emitted.
